audio_addr_gen: RTL and testbench
=================================

Name: audio_addr_gen

Overview:
Parametrised playback address generator for the flash audio path.
- Steps a sample address between START_ADDR and END_ADDR, once per rising edge of a slow sample-rate strobe.
- The strobe is synchronised and edge-detected into the single system clock domain.
- Supports forward/reverse direction, pause, restart, and loop or one-shot end handling.
- Feeds the flash read FSM, which consumes curr_addr on each addr_strobe.

Parameters:
ADDR_W, 23, address width in bits
START_ADDR, 0, first address of the playback region
END_ADDR, 23'h7FFFF, last address of the region; must satisfy END_ADDR > START_ADDR
STEP, 1, address increment per tick; must be at least 1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_tick_in  in  1  slow sample-rate strobe, asynchronous to clk; only its rising edge is used
forward  in  1  1 = increment address, 0 = decrement address
pause  in  1  level-sensitive; while high, ticks are ignored
restart  in  1  one-cycle pulse; reload the region start for the current direction
loop_en  in  1  1 = wrap at the region end, 0 = stop at the region end
curr_addr  out  ADDR_W  current sample address
addr_strobe  out  1  one-cycle pulse in the cycle that curr_addr takes a new value
wrap  out  1  one-cycle pulse, coincident with addr_strobe, when a wrap occurred
done  out  1  high while in DONE

Behaviour:
- Reset values: curr_addr=START_ADDR, addr_strobe=0, wrap=0, done=0, state=RUN, synchroniser flops=0.
- Tick path: sample_tick_in goes through a 2-flop synchroniser, then a delay flop; tick = sync & ~delayed.
  - tick is a one-cycle pulse, 3 clk cycles after the input rising edge.
  - curr_addr and addr_strobe update on the clk edge after tick is high (total 4 cycles).
- States: RUN, PAUSED, DONE.
  - RUN -> PAUSED when pause=1.
  - PAUSED -> RUN when pause=0.
  - RUN -> DONE on a tick that reaches the region end while loop_en=0.
  - DONE -> RUN or PAUSED only on restart; the target follows pause.
  - In PAUSED and DONE, ticks are dropped and curr_addr holds.
- Forward step: if curr_addr + STEP <= END_ADDR, add STEP.
  - Otherwise, if loop_en=1: curr_addr=START_ADDR and wrap=1.
  - Otherwise: curr_addr=END_ADDR, go to DONE, pulse addr_strobe only if the address changed.
- Reverse step (mirror of forward): if curr_addr >= START_ADDR + STEP, subtract STEP.
  - Otherwise, if loop_en=1: curr_addr=END_ADDR and wrap=1.
  - Otherwise: curr_addr=START_ADDR and go to DONE.
- Comparisons use ADDR_W+1 bit arithmetic so there is no overflow at the top of the address space.
- Restart (priority below reset, above everything else):
  - curr_addr = START_ADDR if forward=1, else END_ADDR.
  - done clears and addr_strobe pulses.
  - Any tick in the same cycle is discarded.
- Tick and pause rising in the same cycle: the tick is dropped and the state goes to PAUSED.
- Changing forward mid-stream takes effect on the next tick; no reload occurs.
- Changing forward in DONE has no effect until restart.
- loop_en is sampled only at the end-of-region decision.
- Reset mid-operation: immediate return to reset values on the next clk edge; a pending synchronised tick is discarded.

Optional Feature:
Macro AUDIO_ADDR_GEN_SPEED_EN.
- When defined: adds input port speed [1:0]. The effective step is STEP << speed (x1, x2, x4, x8), and the same boundary rules apply with the effective step.
- When undefined: no speed port; the step is fixed at STEP.

Decomposition:
- Package audio_addr_pkg holds:
  - the state enum: RUN=2'd0, PAUSED=2'd1, DONE=2'd2;
  - the speed-shift constant SPEED_W=2.
- One sub-module, sync_edge_detect: 2-flop synchroniser plus rising-edge pulse, with its own clk/reset. It is instantiated once for sample_tick_in.

Test Plan:
- Forward loop (STEP=1, START=0, END=7, loop_en=1): 9 ticks -> curr_addr 1..7, then 0 with wrap=1 on the 8th tick, then 1.
- Reverse one-shot (forward=0, loop_en=0): restart -> curr_addr=7. Then 7 ticks -> 0 and done=1; a further tick leaves 0, no strobe.
- Pause: after 3 ticks (addr 3), pause=1 for 5 ticks -> addr stays 3 with no strobe. pause=0, then 1 tick -> 4.
- Restart vs tick: restart and tick in the same cycle at addr 5 (forward) -> curr_addr=0, one strobe, no further step.
- Reset mid-run: reset at addr 6 -> next edge curr_addr=0, done=0, state RUN. A tick 2 cycles before reset is discarded.
- Speed (macro on, STEP=1, END=15, loop_en=1): speed=2 -> 0, 4, 8, 12, then 0 with wrap=1.

Source files
------------

// File: rtl/audio_addr_pkg.sv
// Shared types for the audio playback address generator.
package audio_addr_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned SPEED_W = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous strobe, followed by a registered
// rising-edge pulse (one clk wide, three cycles after the input edge).
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_1 <= async_in;
      sync_2 <= sync_1;
      sync_d <= sync_2;
      pulse  <= sync_2 & ~sync_d;
    end
  end

endmodule

// File: rtl/audio_addr_gen.sv
// Playback address generator: steps curr_addr through [START_ADDR, END_ADDR]
// once per sample tick. Define AUDIO_ADDR_GEN_SPEED_EN to add the speed port.
module audio_addr_gen
  import audio_addr_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h7FFFF),
  parameter int unsigned       STEP       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick_in,
  input  logic              forward,
  input  logic              pause,
  input  logic              restart,
  input  logic              loop_en,
`ifdef AUDIO_ADDR_GEN_SPEED_EN
  input  logic [SPEED_W-1:0] speed,
`endif
  output logic [ADDR_W-1:0] curr_addr,
  output logic              addr_strobe,
  output logic              wrap,
  output logic              done
);

  localparam int unsigned EXT_W = ADDR_W + 1;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                strobe_d;
  logic                wrap_d;
  logic                tick;

  logic [EXT_W-1:0]    step_ext;
  logic [EXT_W-1:0]    cur_ext;
  logic [EXT_W-1:0]    start_ext;
  logic [EXT_W-1:0]    end_ext;
  logic [EXT_W-1:0]    sum_ext;
  logic [ADDR_W-1:0]   diff_addr;
  logic                fwd_ok;
  logic                rev_ok;

  sync_edge_detect u_tick_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sample_tick_in),
    .pulse    (tick)
  );

`ifdef AUDIO_ADDR_GEN_SPEED_EN
  assign step_ext = EXT_W'(STEP) << speed;
`else
  assign step_ext = EXT_W'(STEP);
`endif

  // One extra bit keeps the boundary compares free of wraparound.
  assign cur_ext   = {1'b0, curr_addr};
  assign start_ext = {1'b0, START_ADDR};
  assign end_ext   = {1'b0, END_ADDR};
  assign sum_ext   = cur_ext + step_ext;
  assign diff_addr = curr_addr - ADDR_W'(step_ext);
  assign fwd_ok    = (sum_ext <= end_ext);
  assign rev_ok    = (cur_ext >= (start_ext + step_ext));

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = curr_addr;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;
    if (restart) begin
      addr_d   = forward ? START_ADDR : END_ADDR;
      strobe_d = 1'b1;
      state_d  = pause ? PAUSED : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            if (forward) begin
              if (fwd_ok) begin
                addr_d   = sum_ext[ADDR_W-1:0];
                strobe_d = 1'b1;
                if (!loop_en && (sum_ext == end_ext)) state_d = DONE;
              end else if (loop_en) begin
                addr_d   = START_ADDR;
                strobe_d = 1'b1;
                wrap_d   = 1'b1;
              end else begin
                addr_d   = END_ADDR;
                strobe_d = (curr_addr != END_ADDR);
                state_d  = DONE;
              end
            end else begin
              if (rev_ok) begin
                addr_d   = diff_addr;
                strobe_d = 1'b1;
                if (!loop_en && (diff_addr == START_ADDR)) state_d = DONE;
              end else if (loop_en) begin
                addr_d   = END_ADDR;
                strobe_d = 1'b1;
                wrap_d   = 1'b1;
              end else begin
                addr_d   = START_ADDR;
                strobe_d = (curr_addr != START_ADDR);
                state_d  = DONE;
              end
            end
          end
        end
        PAUSED: begin
          if (!pause) state_d = RUN;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      curr_addr   <= START_ADDR;
      addr_strobe <= 1'b0;
      wrap        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      curr_addr   <= addr_d;
      addr_strobe <= strobe_d;
      wrap        <= wrap_d;
      done        <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_audio_addr_gen.sv
// Directed bench for audio_addr_gen with an 8-entry region (START=0, END=7).
module tb_audio_addr_gen;
  import audio_addr_pkg::*;

  localparam int unsigned ADDR_W = 23;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_tick_in;
  logic              forward;
  logic              pause;
  logic              restart;
  logic              loop_en;
`ifdef AUDIO_ADDR_GEN_SPEED_EN
  logic [1:0]        speed;
`endif
  logic [ADDR_W-1:0] curr_addr;
  logic              addr_strobe;
  logic              wrap;
  logic              done;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit fwd;
    bit pse;
    bit rst;
    bit lp;
    bit tck;
    int exp_addr;
    int exp_strobes;
    int exp_wraps;
    bit exp_done;
  } vec_t;

  vec_t vecs[$];

  audio_addr_gen #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (ADDR_W'(0)),
    .END_ADDR   (ADDR_W'(7)),
    .STEP       (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_tick_in (sample_tick_in),
    .forward        (forward),
    .pause          (pause),
    .restart        (restart),
    .loop_en        (loop_en),
`ifdef AUDIO_ADDR_GEN_SPEED_EN
    .speed          (speed),
`endif
    .curr_addr      (curr_addr),
    .addr_strobe    (addr_strobe),
    .wrap           (wrap),
    .done           (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit f, bit p, bit r, bit l, bit t,
                              int a, int s, int w, bit d);
    vec_t v;
    v.fwd = f; v.pse = p; v.rst = r; v.lp = l; v.tck = t;
    v.exp_addr = a; v.exp_strobes = s; v.exp_wraps = w; v.exp_done = d;
    return v;
  endfunction

  // Drive one vector, then watch a fixed 10-cycle window for strobes and wraps.
  task automatic run_vec(input vec_t v, output int strobes, output int wraps);
    forward        = v.fwd;
    pause          = v.pse;
    loop_en        = v.lp;
    restart        = v.rst;
    sample_tick_in = v.tck;
    strobes = 0;
    wraps   = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      restart = 1'b0;
      if (c == 2) sample_tick_in = 1'b0;
      strobes += int'(addr_strobe);
      wraps   += int'(wrap);
    end
  endtask

  task automatic apply_check(input vec_t v, input string tag);
    int s;
    int w;
    run_vec(v, s, w);
    check({tag, " addr"},    int'(curr_addr), v.exp_addr);
    check({tag, " strobes"}, s, v.exp_strobes);
    check({tag, " wraps"},   w, v.exp_wraps);
    check({tag, " done"},    int'(done), int'(v.exp_done));
  endtask

  initial begin
    int s;
    forward = 1'b1; pause = 1'b0; restart = 1'b0; loop_en = 1'b1;
    sample_tick_in = 1'b0; reset = 1'b1;
`ifdef AUDIO_ADDR_GEN_SPEED_EN
    speed = 2'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset addr",   int'(curr_addr), 0);
    check("reset strobe", int'(addr_strobe), 0);
    check("reset wrap",   int'(wrap), 0);
    check("reset done",   int'(done), 0);
    check("reset state",  int'(dut.state_q), int'(RUN));
    reset = 1'b0;
    @(posedge clk); #1;

    // Forward loop: 1..7, wrap to 0, then 1.
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(1, 0, 0, 1, 1, k, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0));
    // Reverse one-shot from the top, ending in DONE at 0.
    vecs.push_back(mk(0, 0, 1, 0, 0, 7, 1, 0, 0));
    for (int k = 6; k >= 1; k--) vecs.push_back(mk(0, 0, 0, 0, 1, k, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 1));
    // Restart forward, three ticks, pause over five ticks, resume.
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 3; k++) vecs.push_back(mk(1, 0, 0, 1, 1, k, 1, 0, 0));
    for (int k = 0; k < 5; k++)  vecs.push_back(mk(1, 1, 0, 1, 1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 4, 1, 0, 0));

    foreach (vecs[i]) apply_check(vecs[i], $sformatf("row%0d", i));

    // Tick latency: strobe exactly four edges after the input rises (addr 4 -> 5).
    sample_tick_in = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 3) sample_tick_in = 1'b0;
      check($sformatf("latency c%0d strobe", c), int'(addr_strobe), int'(c == 4));
    end
    check("latency addr", int'(curr_addr), 5);

    // Restart coincident with the internal tick: restart wins, tick is lost.
    sample_tick_in = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    restart = 1'b1;
    sample_tick_in = 1'b0;
    @(posedge clk); #1;
    restart = 1'b0;
    check("rst_tick addr",   int'(curr_addr), 0);
    check("rst_tick strobe", int'(addr_strobe), 1);
    s = 0;
    repeat (8) begin @(posedge clk); #1; s += int'(addr_strobe); end
    check("rst_tick extra strobes", s, 0);
    check("rst_tick addr hold", int'(curr_addr), 0);

    // Reset mid-run at addr 6 with a tick in flight.
    for (int k = 1; k <= 6; k++) apply_check(mk(1, 0, 0, 1, 1, k, 1, 0, 0), $sformatf("pre_rst%0d", k));
    sample_tick_in = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    sample_tick_in = 1'b0;
    @(posedge clk); #1;
    check("midrst addr",  int'(curr_addr), 0);
    check("midrst done",  int'(done), 0);
    check("midrst state", int'(dut.state_q), int'(RUN));
    reset = 1'b0;
    s = 0;
    repeat (8) begin @(posedge clk); #1; s += int'(addr_strobe); end
    check("midrst dropped tick", s, 0);
    check("midrst addr hold", int'(curr_addr), 0);

`ifdef AUDIO_ADDR_GEN_SPEED_EN
    // x2 then x4 steps with the same wrap rule.
    speed = 2'd1;
    apply_check(mk(1, 0, 0, 1, 1, 2, 1, 0, 0), "spd2 a");
    apply_check(mk(1, 0, 0, 1, 1, 4, 1, 0, 0), "spd2 b");
    apply_check(mk(1, 0, 0, 1, 1, 6, 1, 0, 0), "spd2 c");
    apply_check(mk(1, 0, 0, 1, 1, 0, 1, 1, 0), "spd2 wrap");
    speed = 2'd2;
    apply_check(mk(1, 0, 0, 1, 1, 4, 1, 0, 0), "spd4 a");
    apply_check(mk(1, 0, 0, 1, 1, 0, 1, 1, 0), "spd4 wrap");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
